// File: rtl/lz_denorm.sv
`default_nettype none
// ============================================================================
// Module   : lz_denorm
// Function : iterative right-shift de-normalizer (inverse of a leading-zero
//            count), valid/ready on both sides. Macro LZ_DENORM_NIBBLE_EN
//            enables 4-bit steps while the remaining count is at least 4.
// Revision : 1.0
// ============================================================================
module lz_denorm (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   input  logic [5:0]  in_count,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        out_err
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam logic [5:0] c_max_count = 6'd32;

   state_t      state_q, state_d;
   logic [31:0] data_q,  data_d;
   logic [5:0]  rem_q,   rem_d;
   logic        err_q,   err_d;

   logic        w_nibble;
   logic [5:0]  w_step;
   logic [5:0]  w_rem_sub;
   logic [31:0] w_shifted;
   logic        w_over;
   logic [5:0]  w_clamped;

`ifdef LZ_DENORM_NIBBLE_EN
   assign w_nibble = (rem_q >= 6'd4);
`else
   assign w_nibble = 1'b0;
`endif

   assign w_step    = w_nibble ? 6'd4 : 6'd1;
   assign w_shifted = w_nibble ? {4'b0000, data_q[31:4]} : {1'b0, data_q[31:1]};
   assign w_rem_sub = rem_q - w_step;

   // Counts beyond the word width clamp to a full shift and flag an error.
   assign w_over    = (in_count > c_max_count);
   assign w_clamped = w_over ? c_max_count : in_count;

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      rem_d   = rem_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               data_d  = in_data;
               err_d   = w_over;
               rem_d   = w_clamped;
               state_d = (w_clamped == 6'd0) ? ST_DONE : ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            data_d = w_shifted;
            rem_d  = w_rem_sub;
            if (w_rem_sub == 6'd0) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         data_q  <= 32'd0;
         rem_q   <= 6'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         rem_q   <= rem_d;
         err_q   <= err_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign out_data  = data_q;
   assign out_err   = err_q;

endmodule
`default_nettype wire
